// File: rtl/dbg_trace_pkg.sv
// Shared types and constants for the debug trace capture block.
// A snapshot is the seven 8-bit cpu debug ports packed with port1 in the low byte.
package dbg_trace_pkg;

    localparam int NPORTS = 7;
    localparam int PORT_W = 8;
    localparam int SNAP_W = NPORTS * PORT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DUMP  = 2'd3
    } state_t;

    typedef logic [SNAP_W-1:0] snap_t;

    // Byte idx of a snapshot: idx 0 is port1, idx NPORTS-1 is port7.
    function automatic logic [PORT_W-1:0] snap_byte(input snap_t s, input logic [2:0] idx);
        logic [PORT_W-1:0] b;
        b = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (idx == i[2:0]) begin
                b = s[i*PORT_W +: PORT_W];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Snapshot store: simple dual-port RAM, synchronous write and synchronous read.
// Read latency 1 cycle; a read of the address being written returns the new data.
// No backpressure: one write and one read may issue every cycle.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 56,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        // Write-first so the DUMP prefetch can be issued during the final capture write.
        if (we && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/debug_trace_capture.sv
// Circular trace of cpu debug snapshots, frozen POST_TRIG samples after a trigger, then streamed bytewise.
// Latency: first byte valid 1 cycle after entering DUMP; then 1 byte/cycle including entry boundaries.
// Backpressure: out_data/out_valid held while !out_ready; capture is frozen, so nothing is lost.
module debug_trace_capture #(
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       arm,
    input  logic       trigger,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       triggered
);

    import dbg_trace_pkg::*;

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     FULL      = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   POST_INIT = AW'(POST_TRIG);
    localparam logic [2:0]      LAST_BYTE = 3'(NPORTS - 1);

    state_t          state;
    state_t          state_nxt;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   wr_ptr_inc;
    logic [AW:0]     fill;
    logic [AW:0]     fill_inc;
    logic [AW-1:0]   post_cnt;

    logic            wr_en;
    logic [AW-1:0]   start_addr;
    logic [AW-1:0]   start_nxt;
    logic [AW-1:0]   rd_addr;

    snap_t           snap_in;
    snap_t           rd_data;
    snap_t           snap_q;
    logic [2:0]      byte_idx;
    logic [AW:0]     cur_entry;
    logic            last_entry;
    logic            accept;

    assign snap_in = {debug_port7, debug_port6, debug_port5, debug_port4,
                      debug_port3, debug_port2, debug_port1};

    assign wr_ptr_inc = wr_ptr + AW'(1);
    assign fill_inc   = (fill == FULL) ? fill : fill + 1'b1;

    // Oldest entry of the window; wr_ptr and fill are frozen throughout DUMP.
    assign start_addr = (fill == FULL) ? wr_ptr : '0;
    assign start_nxt  = (fill_inc == FULL) ? wr_ptr_inc : '0;

    // Outside DUMP the read targets the start of the window as it will stand after this
    // cycle's write, so entry 0 is already in rd_data on the first DUMP cycle. In DUMP the
    // read runs one entry ahead of the one being streamed.
    assign rd_addr = (state == DUMP) ? start_addr + cur_entry[AW-1:0] + AW'(1)
                                     : start_nxt;

    assign accept     = out_valid && out_ready;
    assign last_entry = (cur_entry == fill - 1'b1);

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SNAP_W)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (snap_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (trigger) begin
                    state_nxt = (POST_TRIG == 0) ? DUMP : POST;
                end
            end
            POST: begin
                if (post_cnt == AW'(1)) begin
                    state_nxt = DUMP;
                end
            end
            DUMP: begin
                if (accept && out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        triggered = 1'b0;
        wr_en     = 1'b0;
        case (state)
            ARMED: begin
                busy  = 1'b1;
                wr_en = 1'b1;
            end
            POST: begin
                busy      = 1'b1;
                triggered = 1'b1;
                wr_en     = 1'b1;
            end
            DUMP: begin
                busy      = 1'b1;
                triggered = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            wr_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        wr_ptr <= '0;
                        fill   <= '0;
                    end
                end
                ARMED: begin
                    wr_ptr <= wr_ptr_inc;
                    fill   <= fill_inc;
                    if (trigger) begin
                        post_cnt <= POST_INIT;
                    end
                end
                POST: begin
                    wr_ptr   <= wr_ptr_inc;
                    fill     <= fill_inc;
                    post_cnt <= post_cnt - AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            byte_idx  <= '0;
            cur_entry <= '0;
            snap_q    <= '0;
        end else if (state != DUMP) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            byte_idx  <= '0;
            cur_entry <= '0;
        end else if (!out_valid) begin
            // First DUMP cycle: entry 0 was prefetched while the last capture write happened.
            snap_q    <= rd_data;
            out_data  <= snap_byte(rd_data, 3'd0);
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            byte_idx  <= '0;
        end else if (accept) begin
            if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (byte_idx == LAST_BYTE) begin
                snap_q    <= rd_data;
                out_data  <= snap_byte(rd_data, 3'd0);
                byte_idx  <= '0;
                cur_entry <= cur_entry + 1'b1;
                out_last  <= 1'b0;
            end else begin
                out_data  <= snap_byte(snap_q, byte_idx + 3'd1);
                byte_idx  <= byte_idx + 3'd1;
                out_last  <= (byte_idx == LAST_BYTE - 3'd1) && last_entry;
            end
        end
    end

endmodule

// File: tb/tb_debug_trace_capture.sv
// Bench: two captures (POST_TRIG=8 and POST_TRIG=0) checked against the window of
// snapshots the bench itself drove, plus literal pins on latency and window contents.
module tb_debug_trace_capture;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       nreset, arm, trigger, arm_b, trigger_b, ready_a, ready_b;
    logic [7:0] dp [7];

    logic [7:0] a_data, b_data;
    logic       a_valid, a_last, a_busy, a_trig;
    logic       b_valid, b_last, b_busy, b_trig;

    int vectors = 0;
    int miscompares = 0;
    int acc_a = 0;
    int acc_b = 0;
    bit mon_en = 1'b0;

    logic [55:0] plan [$];
    logic [7:0]  exp_a [$];
    logic [7:0]  exp_b [$];
    bit          stall [2];
    logic [7:0]  held [2];

    debug_trace_capture #(.DEPTH(DEPTH), .POST_TRIG(8)) dut_a (
        .clk(clk), .nreset(nreset), .arm(arm), .trigger(trigger),
        .debug_port1(dp[0]), .debug_port2(dp[1]), .debug_port3(dp[2]), .debug_port4(dp[3]),
        .debug_port5(dp[4]), .debug_port6(dp[5]), .debug_port7(dp[6]),
        .out_data(a_data), .out_valid(a_valid), .out_ready(ready_a), .out_last(a_last),
        .busy(a_busy), .triggered(a_trig)
    );

    debug_trace_capture #(.DEPTH(DEPTH), .POST_TRIG(0)) dut_b (
        .clk(clk), .nreset(nreset), .arm(arm_b), .trigger(trigger_b),
        .debug_port1(dp[0]), .debug_port2(dp[1]), .debug_port3(dp[2]), .debug_port4(dp[3]),
        .debug_port5(dp[4]), .debug_port6(dp[5]), .debug_port7(dp[6]),
        .out_data(b_data), .out_valid(b_valid), .out_ready(ready_b), .out_last(b_last),
        .busy(b_busy), .triggered(b_trig)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string got, input string want);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Port k carries c + 37*k, so port1 equals the sample number c.
    function automatic logic [55:0] snap_of(input int c);
        logic [55:0] s;
        for (int k = 0; k < 7; k++) s[8*k +: 8] = 8'(c + 37*k);
        return s;
    endfunction

    task automatic set_snap(input logic [55:0] s);
        for (int k = 0; k < 7; k++) dp[k] = s[8*k +: 8];
    endtask

    task automatic ctl(input bit for_b, input logic a, input logic t);
        arm = for_b ? 1'b0 : a;
        trigger = for_b ? 1'b0 : t;
        arm_b = for_b ? a : 1'b0;
        trigger_b = for_b ? t : 1'b0;
    endtask

    // Model: the dump is the newest DEPTH snapshots (or all of them if fewer) taken from
    // the first armed cycle through the last post-trigger cycle, oldest first, port1 first.
    task automatic make_plan(input bit for_b, input int base, input int n_total);
        int first;
        logic [7:0] q [$];
        plan.delete();
        for (int i = 0; i < n_total; i++) plan.push_back(snap_of(base + i));
        first = (n_total > DEPTH) ? n_total - DEPTH : 0;
        for (int e = first; e < n_total; e++)
            for (int k = 0; k < 7; k++) q.push_back(plan[e][8*k +: 8]);
        if (for_b) begin exp_b = q; acc_b = 0; end
        else begin exp_a = q; acc_a = 0; end
    endtask

    task automatic capture(input bit for_b, input int n_armed, input int post, input bit noisy);
        ctl(for_b, 1'b1, noisy);
        set_snap(snap_of(200));
        step();
        if (noisy) begin
            chk("arm_with_trigger_busy", a_busy, 1);
            chk("arm_with_trigger_triggered", a_trig, 0);
        end
        for (int i = 0; i < n_armed + post; i++) begin
            set_snap(plan[i]);
            if (i < n_armed) ctl(for_b, noisy && i == 0 && n_armed > 1, i == n_armed - 1);
            else ctl(for_b, noisy && i == n_armed + 3, noisy && i == n_armed + 2);
            step();
        end
        ctl(for_b, 1'b0, 1'b0);
        set_snap(snap_of(250));
    endtask

    task automatic drain(input bit for_b, input bit toggle, input int budget);
        int n = 0;
        while (n < budget && ((for_b ? b_busy : a_busy) ||
                              (for_b ? exp_b.size() : exp_a.size()) != 0)) begin
            if (for_b) ready_b = toggle ? ~ready_b : 1'b1;
            else ready_a = toggle ? ~ready_a : 1'b1;
            step();
            n++;
        end
        if (n >= budget) fail("drain_timeout", "still busy", "dump complete");
        ready_a = 1'b1;
        ready_b = 1'b1;
    endtask

    always @(negedge clk) begin : compare
        logic v, r, l, bz, have;
        logic [7:0] d, e;
        int rem;
        for (int u = 0; u < 2; u++) begin
            v  = (u == 0) ? a_valid : b_valid;
            r  = (u == 0) ? ready_a : ready_b;
            l  = (u == 0) ? a_last  : b_last;
            bz = (u == 0) ? a_busy  : b_busy;
            d  = (u == 0) ? a_data  : b_data;
            if (!mon_en) begin
                stall[u] = 1'b0;
            end else begin
                if (stall[u]) begin
                    chk(u == 0 ? "a_hold_valid" : "b_hold_valid", v, 1);
                    chk(u == 0 ? "a_hold_data" : "b_hold_data", d, held[u]);
                end
                if (!bz) chk(u == 0 ? "a_valid_idle" : "b_valid_idle", v, 0);
                if (v && r) begin
                    have = 1'b0; e = '0; rem = 0;
                    if (u == 0 && exp_a.size() != 0) begin
                        e = exp_a.pop_front(); rem = exp_a.size(); have = 1'b1; acc_a++;
                    end else if (u == 1 && exp_b.size() != 0) begin
                        e = exp_b.pop_front(); rem = exp_b.size(); have = 1'b1; acc_b++;
                    end
                    if (!have) fail(u == 0 ? "a_extra_byte" : "b_extra_byte", "a byte", "none");
                    else begin
                        chk(u == 0 ? "a_byte" : "b_byte", d, e);
                        chk(u == 0 ? "a_last" : "b_last", l, rem == 0);
                    end
                end
                stall[u] = v && !r;
                held[u]  = d;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no summary, expected bench completion");
        $fatal(1);
    end

    initial begin
        nreset = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        ctl(1'b0, 1'b0, 1'b0);
        set_snap(snap_of(0));
        step(); step();
        nreset = 1'b0;
        chk("rst_valid", a_valid, 0);
        chk("rst_last", a_last, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_triggered", a_trig, 0);
        chk("rst_data", a_data, 0);
        chk("rst_b_busy", b_busy, 0);
        mon_en = 1'b1;

        // Short window: trigger on the 3rd armed cycle, 11 entries.
        make_plan(1'b0, 0, 11);
        chk("t2_model_bytes", exp_a.size(), 77);
        capture(1'b0, 3, 8, 1'b0);
        chk("t2_dump_entry_valid", a_valid, 0);
        chk("t2_dump_entry_triggered", a_trig, 1);
        step();
        chk("t2_first_valid", a_valid, 1);
        chk("t2_first_byte", a_data, 8'h00);
        drain(1'b0, 1'b0, 400);
        chk("t2_bytes", acc_a, 77);

        // Wrap: trigger at sample 40; window is samples 33..48, trigger at entry 7.
        make_plan(1'b0, 0, 49);
        chk("t3_model_bytes", exp_a.size(), 112);
        chk("t3_model_oldest", exp_a[0], 8'h21);
        chk("t3_model_trigger_entry", exp_a[49], 8'h28);
        capture(1'b0, 41, 8, 1'b0);
        drain(1'b0, 1'b0, 400);
        chk("t3_bytes", acc_a, 112);

        // Same capture with out_ready toggling every cycle.
        make_plan(1'b0, 0, 49);
        capture(1'b0, 41, 8, 1'b0);
        drain(1'b0, 1'b1, 600);
        chk("t4_bytes", acc_a, 112);

        // Ignored inputs.
        ctl(1'b0, 1'b0, 1'b1);
        step();
        ctl(1'b0, 1'b0, 1'b0);
        chk("t5_trigger_idle_busy", a_busy, 0);
        make_plan(1'b0, 60, 13);
        capture(1'b0, 5, 8, 1'b1);
        drain(1'b0, 1'b0, 400);
        chk("t5_bytes", acc_a, 91);

        // Reset in the middle of a dump.
        make_plan(1'b0, 100, 49);
        capture(1'b0, 41, 8, 1'b0);
        repeat (10) step();
        chk("t1_mid_dump_busy", a_busy, 1);
        mon_en = 1'b0;
        nreset = 1'b1;
        step(); step();
        nreset = 1'b0;
        exp_a.delete();
        chk("t1_rst_valid", a_valid, 0);
        chk("t1_rst_busy", a_busy, 0);
        step();
        chk("t1_after_valid", a_valid, 0);
        chk("t1_after_busy", a_busy, 0);
        chk("t1_after_triggered", a_trig, 0);
        mon_en = 1'b1;

        // POST_TRIG=0 build: wrapped window ending at the trigger sample.
        make_plan(1'b1, 0, 20);
        chk("t6_model_bytes", exp_b.size(), 112);
        chk("t6_model_oldest", exp_b[0], 8'h04);
        chk("t6_model_last_entry", exp_b[105], 8'h13);
        capture(1'b1, 20, 0, 1'b0);
        chk("t6_dump_next_cycle", b_trig, 1);
        chk("t6_dump_entry_valid", b_valid, 0);
        drain(1'b1, 1'b0, 400);
        chk("t6_bytes", acc_b, 112);

        // Trigger on the very first armed cycle: a single-entry window.
        make_plan(1'b1, 50, 1);
        chk("t6b_model_first", exp_b[0], 8'h32);
        capture(1'b1, 1, 0, 1'b0);
        drain(1'b1, 1'b0, 100);
        chk("t6b_bytes", acc_b, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
